vec_addsub_pipe: RTL and testbench
==================================

Name: vec_addsub_pipe

Overview:
Parametrised, pipelined lane-wise vector add/subtract unit. It generalises the fixed i8v4 adder in four ways: lane count, lane width, pipeline depth and arithmetic mode (wrap/saturate) are all parameters. It adds a valid/ready handshake with backpressure and per-lane signed-overflow flags. It is a compute primitive for vector datapaths and is exercised by self-checking fail/finish benches.

Parameters:
WIDTH, 8, bits per lane (2..32)
LANES, 4, number of lanes (1..16)
LATENCY, 1, pipeline stages from accept to out_valid (1..4)
SAT, 0, 0 = wrap-around two's complement; 1 = signed saturation

Ports:
clock  input  1  sole clock, rising edge
reset  input  1  synchronous, active-high
in_valid  input  1  operand beat valid
in_ready  output  1  unit can accept a beat this cycle
op  input  1  0 = a+b, 1 = a-b; sampled with the beat
a  input  LANES*WIDTH  lane i = a[i*WIDTH +: WIDTH], signed
b  input  LANES*WIDTH  lane i = b[i*WIDTH +: WIDTH], signed
out_valid  output  1  result beat valid
out_ready  input  1  consumer accepts the result
y  output  LANES*WIDTH  lane results, same packing as a
ovf  output  LANES  per-lane signed overflow of the returned beat

Behaviour:
- Interface: one clock, clock; reset is synchronous and active-high, reset.
- Reset (sampled at a rising edge):
  - all stage valid bits = 0, out_valid = 0, y = 0, ovf = 0.
  - in_ready = 1 in the first cycle after reset is deasserted.
  - Reset mid-operation discards every in-flight beat; no partial output is produced.
- Pipeline structure: LATENCY register stages, each holding a valid bit, op, operands or results, and ovf.
  - Arithmetic is computed combinationally into stage 1; later stages only carry data.
  - Stage LATENCY drives y, ovf and out_valid directly from registers; no combinational path from inputs to outputs.
- Advance rule: advance = !out_valid | out_ready.
  - in_ready = advance (combinational from out_valid and out_ready only).
  - When advance = 1, every stage loads from the stage before it. Stage 1 loads the input beat with valid = in_valid & in_ready.
  - When advance = 0, all stages hold. Bubbles are not collapsed.
- Handshakes:
  - Accept happens when in_valid & in_ready. Transfer happens when out_valid & out_ready.
  - Unstalled latency: a beat accepted at edge k appears with out_valid = 1 after edge k+LATENCY-1, i.e. LATENCY cycles.
  - Throughput is 1 beat/cycle while out_ready = 1.
  - Simultaneous transfer and accept in one cycle is legal; nothing is lost or duplicated.
- Per-lane arithmetic:
  - Full result r = a_i ± b_i computed at WIDTH+1 bits.
  - ovf_i = 1 iff r is outside [-2^(WIDTH-1), 2^(WIDTH-1)-1].
  - SAT=0: y_i = r[WIDTH-1:0].
  - SAT=1: y_i = signed max on positive overflow, signed min on negative overflow, otherwise r[WIDTH-1:0].
  - Subtraction of signed min is handled by the WIDTH+1-bit compute (e.g. 0 - (-128) overflows, 8-bit).
  - Lanes are fully independent; there are no carries between lanes.
- Hold stability: while out_valid = 1 & out_ready = 0, y and ovf stay stable.
- Beat ordering is preserved. in_valid with in_ready = 0 has no effect; the producer must hold the beat.

Test Plan:
1. Default params, op=0, a={1,2,2,-4}, b={1,0,3,1} (lane3..lane0), out_ready=1 -> one cycle later out_valid=1, y={2,2,5,-3}, ovf=0.
2. SAT=0 vs SAT=1, lane0 = 127+1, lane1 = -128-1 (op=1, b=1), lane2 = 0-(-128) (op=1) ->
   - SAT=0: y0=-128, y1=127, y2=-128.
   - SAT=1: y0=127, y1=-128, y2=127.
   - Both cases: ovf[2:0]=3'b111.
3. LATENCY=3, 8 back-to-back beats with a_i = beat number, b_i = 1, out_ready=1 -> first out_valid 3 cycles after first accept, 8 consecutive results of beat+1, in_ready constantly 1.
4. LATENCY=2, stream of beats with out_ready=0 for 5 cycles mid-stream -> in_ready=0 during the stall, y/ovf frozen, no beat lost or repeated, order preserved after release.
5. Reset asserted for 1 cycle while 2 beats are in flight (LATENCY=2) -> out_valid=0, y=0, ovf=0 next cycle, neither beat ever emerges, a new beat afterwards returns correctly.
6. WIDTH=16, LANES=8, random op/a/b over 1000 beats with random out_ready -> every lane matches the reference model (wrap or sat per SAT) with exact ovf; bench asserts fail=0, finish=1.

Source files
------------

// File: rtl/vec_addsub_pipe.sv
`default_nettype none
// ============================================================================
// Module      : vec_addsub_pipe
// Description : Pipelined lane-wise signed vector add/subtract with optional
//               saturation, per-lane overflow flags and valid/ready flow.
// Revision    : 1.0 - initial release
// ============================================================================
module vec_addsub_pipe #(
    parameter int WIDTH   = 8,
    parameter int LANES   = 4,
    parameter int LATENCY = 1,
    parameter int SAT     = 0
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   op,
    input  logic [LANES*WIDTH-1:0] a,
    input  logic [LANES*WIDTH-1:0] b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*WIDTH-1:0] y,
    output logic [LANES-1:0]       ovf
);

    localparam int c_vec_w = LANES * WIDTH;

    logic                             w_advance;
    logic [c_vec_w-1:0]               w_res;
    logic [LANES-1:0]                 w_ovf;
    logic [LATENCY-1:0]               r_vld;
    logic [LATENCY-1:0][c_vec_w-1:0]  r_y;
    logic [LATENCY-1:0][LANES-1:0]    r_ovf;

    // The whole pipe moves in lock-step; a stalled head freezes every stage.
    assign w_advance = !out_valid || out_ready;
    assign in_ready  = w_advance;

    generate
        for (genvar i = 0; i < LANES; i++) begin : g_lane
            logic signed [WIDTH:0] w_a_ext;
            logic signed [WIDTH:0] w_b_ext;
            logic signed [WIDTH:0] w_full;
            logic                  w_lane_ovf;

            // One extra bit holds every a+b and a-b exactly, including 0-min.
            assign w_a_ext    = {a[i*WIDTH+WIDTH-1], a[i*WIDTH +: WIDTH]};
            assign w_b_ext    = {b[i*WIDTH+WIDTH-1], b[i*WIDTH +: WIDTH]};
            assign w_full     = op ? (w_a_ext - w_b_ext) : (w_a_ext + w_b_ext);
            assign w_lane_ovf = w_full[WIDTH] ^ w_full[WIDTH-1];
            assign w_ovf[i]   = w_lane_ovf;

            if (SAT != 0) begin : g_sat
                assign w_res[i*WIDTH +: WIDTH] = !w_lane_ovf ? w_full[WIDTH-1:0] :
                    (w_full[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}}
                                   : {1'b0, {(WIDTH-1){1'b1}}});
            end else begin : g_wrap
                assign w_res[i*WIDTH +: WIDTH] = w_full[WIDTH-1:0];
            end
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            r_vld <= '0;
            r_y   <= '0;
            r_ovf <= '0;
        end else if (w_advance) begin
            r_vld[0] <= in_valid && in_ready;
            r_y[0]   <= w_res;
            r_ovf[0] <= w_ovf;
            for (int s = 1; s < LATENCY; s++) begin
                r_vld[s] <= r_vld[s-1];
                r_y[s]   <= r_y[s-1];
                r_ovf[s] <= r_ovf[s-1];
            end
        end
    end

    assign out_valid = r_vld[LATENCY-1];
    assign y         = r_y[LATENCY-1];
    assign ovf       = r_ovf[LATENCY-1];

endmodule
`default_nettype wire

// File: tb/tb_vec_addsub_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_vec_addsub_pipe
// Description : Self-checking bench for vec_addsub_pipe in three configurations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vec_addsub_pipe;

    typedef struct packed {
        logic [127:0] y;
        logic [7:0]   ovf;
    } exp_t;

    logic         clock = 1'b0;
    logic         reset;
    logic [2:0]   iv;
    logic [2:0]   op_s;
    logic [2:0]   or_s;
    wire  [2:0]   ir;
    wire  [2:0]   ov;
    logic [31:0]  a0, b0, a1, b1;
    logic [127:0] a2, b2;
    wire  [31:0]  y0, y1;
    wire  [127:0] y2;
    wire  [3:0]   ovf0, ovf1;
    wire  [7:0]   ovf2;
    logic [127:0] yv [3];
    logic [7:0]   ovfv [3];
    logic [127:0] av [3];
    logic [127:0] bv [3];

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb_q [3][$];

    always #5 clock = ~clock;

    vec_addsub_pipe #(.WIDTH(8), .LANES(4), .LATENCY(1), .SAT(0)) u_dut0 (
        .clock(clock), .reset(reset), .in_valid(iv[0]), .in_ready(ir[0]), .op(op_s[0]),
        .a(a0), .b(b0), .out_valid(ov[0]), .out_ready(or_s[0]), .y(y0), .ovf(ovf0));
    vec_addsub_pipe #(.WIDTH(8), .LANES(4), .LATENCY(3), .SAT(1)) u_dut1 (
        .clock(clock), .reset(reset), .in_valid(iv[1]), .in_ready(ir[1]), .op(op_s[1]),
        .a(a1), .b(b1), .out_valid(ov[1]), .out_ready(or_s[1]), .y(y1), .ovf(ovf1));
    vec_addsub_pipe #(.WIDTH(16), .LANES(8), .LATENCY(2), .SAT(0)) u_dut2 (
        .clock(clock), .reset(reset), .in_valid(iv[2]), .in_ready(ir[2]), .op(op_s[2]),
        .a(a2), .b(b2), .out_valid(ov[2]), .out_ready(or_s[2]), .y(y2), .ovf(ovf2));

    always_comb begin
        yv[0] = {96'b0, y0};  yv[1] = {96'b0, y1};  yv[2] = y2;
        ovfv[0] = {4'b0, ovf0}; ovfv[1] = {4'b0, ovf1}; ovfv[2] = ovf2;
        av[0] = {96'b0, a0};  av[1] = {96'b0, a1};  av[2] = a2;
        bv[0] = {96'b0, b0};  bv[1] = {96'b0, b1};  bv[2] = b2;
    end

    function automatic int cfg_w(int k);   return (k == 2) ? 16 : 8; endfunction
    function automatic int cfg_l(int k);   return (k == 2) ? 8 : 4;  endfunction
    function automatic int cfg_lat(int k); return (k == 0) ? 1 : ((k == 1) ? 3 : 2); endfunction
    function automatic bit cfg_sat(int k); return (k == 1); endfunction

    // Reference: integer arithmetic per lane, then range check and clamp.
    function automatic exp_t model(int k, bit o, logic [127:0] xa, logic [127:0] xb);
        exp_t   r    = '0;
        int     w    = cfg_w(k);
        longint lim  = longint'(1) <<< (w - 1);
        longint mask = (longint'(1) <<< w) - 1;
        for (int i = 0; i < cfg_l(k); i++) begin
            longint x = longint'(xa >> (i * w)) & mask;
            longint z = longint'(xb >> (i * w)) & mask;
            longint s;
            if (x >= lim) x = x - 2 * lim;
            if (z >= lim) z = z - 2 * lim;
            s = o ? (x - z) : (x + z);
            r.ovf[i] = (s >= lim) || (s < -lim);
            if (cfg_sat(k) && s >= lim) s = lim - 1;
            if (cfg_sat(k) && s < -lim) s = -lim;
            r.y = r.y | (128'(s & mask) << (i * w));
        end
        return r;
    endfunction

    function automatic logic [127:0] rep(int k, longint v);
        logic [127:0] r    = '0;
        longint       mask = (longint'(1) <<< cfg_w(k)) - 1;
        for (int i = 0; i < cfg_l(k); i++)
            r = r | (128'(v & mask) << (i * cfg_w(k)));
        return r;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", nm, act, exp_v);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic drive(input int k, input bit v, input bit o, input logic [127:0] xa,
                         input logic [127:0] xb);
        iv[k]   = v;
        op_s[k] = o;
        case (k)
            0:       begin a0 = xa[31:0]; b0 = xb[31:0]; end
            1:       begin a1 = xa[31:0]; b1 = xb[31:0]; end
            default: begin a2 = xa;       b2 = xb;       end
        endcase
    endtask

    // Holds the beat until an edge where in_ready was high; returns edges spent.
    task automatic send(input int k, input bit o, input logic [127:0] xa,
                        input logic [127:0] xb, output int tries);
        bit acc = 1'b0;
        tries = 0;
        drive(k, 1'b1, o, xa, xb);
        while (!acc && tries < 200) begin
            @(negedge clock);
            acc = ir[k];
            @(posedge clock);
            #1;
            tries++;
        end
        chk($sformatf("send_accept_k%0d", k), {127'b0, acc}, 128'd1);
        drive(k, 1'b0, o, xa, xb);
    endtask

    task automatic expect_out(input int k, input string nm, input logic [127:0] ey,
                              input logic [7:0] eovf);
        int t = 0;
        while (!ov[k] && t < 20) begin
            tick(1);
            t++;
        end
        chk({nm, "_latency"}, 128'(t), 128'(cfg_lat(k) - 1));
        chk({nm, "_y"}, yv[k], ey);
        chk({nm, "_ovf"}, {120'b0, ovfv[k]}, {120'b0, eovf});
        tick(1);
    endtask

    task automatic run_random(input int k, input int nbeats);
        bit done = 1'b0;
        int tr;
        fork
            begin
                for (int j = 0; j < nbeats; j++) begin
                    logic [127:0] ra = {$urandom(), $urandom(), $urandom(), $urandom()};
                    logic [127:0] rb = {$urandom(), $urandom(), $urandom(), $urandom()};
                    if ($urandom_range(0, 7) == 0) ra = rep(k, -(longint'(1) <<< (cfg_w(k) - 1)));
                    if ($urandom_range(0, 7) == 0) rb = rep(k, -(longint'(1) <<< (cfg_w(k) - 1)));
                    if ($urandom_range(0, 3) == 0) tick(1);
                    send(k, 1'($urandom_range(0, 1)), ra, rb, tr);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    or_s[k] = ($urandom_range(0, 3) != 0);
                    tick(1);
                end
                or_s[k] = 1'b1;
            end
        join
    endtask

    // Scoreboard: every cycle, for every unit, check flow rules and transfers.
    initial begin
        logic [127:0] prev_y [3];
        logic [7:0]   prev_ovf [3];
        bit           held [3];
        exp_t         e;
        for (int k = 0; k < 3; k++) held[k] = 1'b0;
        forever begin
            @(negedge clock);
            for (int k = 0; k < 3; k++) begin
                if (reset) begin
                    sb_q[k].delete();
                    held[k] = 1'b0;
                end else begin
                    chk($sformatf("in_ready_rule_k%0d", k), {127'b0, ir[k]},
                        {127'b0, !ov[k] || or_s[k]});
                    if (held[k]) begin
                        chk($sformatf("hold_valid_k%0d", k), {127'b0, ov[k]}, 128'd1);
                        chk($sformatf("hold_y_k%0d", k), yv[k], prev_y[k]);
                        chk($sformatf("hold_ovf_k%0d", k), {120'b0, ovfv[k]}, {120'b0, prev_ovf[k]});
                    end
                    if (ov[k] && or_s[k]) begin
                        n_checks++;
                        if (sb_q[k].size() == 0) begin
                            n_fail++;
                            $display("FAIL unexpected_beat_k%0d: actual y %0h required no beat", k, yv[k]);
                        end else begin
                            e = sb_q[k].pop_front();
                            n_checks--;
                            chk($sformatf("sb_y_k%0d", k), yv[k], e.y);
                            chk($sformatf("sb_ovf_k%0d", k), {120'b0, ovfv[k]}, {120'b0, e.ovf});
                        end
                    end
                    if (iv[k] && ir[k]) sb_q[k].push_back(model(k, op_s[k], av[k], bv[k]));
                    held[k]     = ov[k] && !or_s[k];
                    prev_y[k]   = yv[k];
                    prev_ovf[k] = ovfv[k];
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int   tr;
        exp_t m;
        reset = 1'b1;
        iv = '0; op_s = '0; or_s = '0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0; a2 = '0; b2 = '0;
        tick(3);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_out_valid_k%0d", k), {127'b0, ov[k]}, 128'd0);
            chk($sformatf("rst_y_k%0d", k), yv[k], 128'd0);
            chk($sformatf("rst_ovf_k%0d", k), {120'b0, ovfv[k]}, 128'd0);
            chk($sformatf("rst_in_ready_k%0d", k), {127'b0, ir[k]}, 128'd1);
        end

        // Hand-computed pins on the reference itself.
        m = model(0, 1'b0, 128'h010202FC, 128'h01000301);
        chk("model_t1_y", m.y, 128'h020205FD);
        m = model(1, 1'b1, 128'h05008080, 128'h03800101);
        chk("model_t2_sat_y", m.y, 128'h027F8080);
        chk("model_t2_sat_ovf", {120'b0, m.ovf}, 128'h7);

        // Basic add, then overflow corners in wrap and saturating units.
        or_s[0] = 1'b1;
        or_s[1] = 1'b1;
        send(0, 1'b0, 128'h010202FC, 128'h01000301, tr);
        expect_out(0, "t1", 128'h020205FD, 8'h0);
        send(0, 1'b0, 128'h0000007F, 128'h00000001, tr);
        expect_out(0, "t2a_wrap", 128'h00000080, 8'h1);
        send(0, 1'b1, 128'h05008080, 128'h03800101, tr);
        expect_out(0, "t2b_wrap", 128'h02807F7F, 8'h7);
        send(1, 1'b0, 128'h0000007F, 128'h00000001, tr);
        expect_out(1, "t2a_sat", 128'h0000007F, 8'h1);
        send(1, 1'b1, 128'h05008080, 128'h03800101, tr);
        expect_out(1, "t2b_sat", 128'h027F8080, 8'h7);

        // Back-to-back stream through the three-stage unit.
        for (int j = 0; j < 10; j++) begin
            if (j < 8) begin
                send(1, 1'b0, rep(1, j), rep(1, 1), tr);
                chk("t3_one_cycle_accept", 128'(tr), 128'd1);
            end else begin
                tick(1);
            end
            chk($sformatf("t3_valid_%0d", j), {127'b0, ov[1]}, {127'b0, j >= 2});
            if (j >= 2) chk($sformatf("t3_y_%0d", j), yv[1], rep(1, j - 1));
        end
        tick(1);
        chk("t3_drained", {127'b0, ov[1]}, 128'd0);

        // Five-cycle consumer stall in the middle of a stream.
        or_s[2] = 1'b1;
        fork
            begin
                for (int j = 0; j < 10; j++)
                    send(2, 1'(j % 2), rep(2, 100 * j - 300), rep(2, 7 * j + 1), tr);
            end
            begin
                tick(4);
                or_s[2] = 1'b0;
                repeat (5) begin
                    @(negedge clock);
                    chk("t4_stall_in_ready", {127'b0, ir[2]}, 128'd0);
                    @(posedge clock);
                    #1;
                end
                or_s[2] = 1'b1;
            end
        join
        tick(5);

        // Reset with two beats in flight; neither may ever come out.
        or_s[2] = 1'b0;
        send(2, 1'b0, rep(2, 11), rep(2, 22), tr);
        send(2, 1'b0, rep(2, 33), rep(2, 44), tr);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        chk("t5_out_valid", {127'b0, ov[2]}, 128'd0);
        chk("t5_y", yv[2], 128'd0);
        chk("t5_ovf", {120'b0, ovfv[2]}, 128'd0);
        or_s[2] = 1'b1;
        repeat (4) begin
            tick(1);
            chk("t5_no_ghost", {127'b0, ov[2]}, 128'd0);
        end
        send(2, 1'b1, rep(2, 1000), rep(2, -3000), tr);
        expect_out(2, "t5_new", rep(2, 4000), 8'h00);

        run_random(2, 1000);
        run_random(1, 200);

        or_s = 3'b111;
        tick(10);
        for (int k = 0; k < 3; k++)
            chk($sformatf("drain_empty_k%0d", k), 128'(sb_q[k].size()), 128'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
